// File: rtl/clock_divider_gen_if.sv
// Divisor load channel for clock_divider_gen: requested divisor, load strobe,
// shadow-free indication and illegal-divisor pulse.
interface clock_divider_gen_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] div_in;
  logic             div_valid;
  logic             div_ready;
  logic             div_err;

  modport master (output div_in, div_valid, input  div_ready, div_err);
  modport slave  (input  div_in, div_valid, output div_ready, div_err);
endinterface

// File: rtl/clock_divider_gen.sv
// Programmable integer clock divider (IDLE/RUN/STOP) with shadowed divisor and
// half-cycle extension for odd divisors. Define CLKDIV_TICK_EN to add the tick port.
module clock_divider_gen #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  clock_divider_gen_if.slave  div,
  output logic                clk_out,
  output logic                running
`ifdef CLKDIV_TICK_EN
  ,
  output logic                tick
`endif
);

  if (DEFAULT_DIV < 2 || longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_default
    $error("clock_divider_gen: DEFAULT_DIV out of range 2..2^WIDTH-1");
  end

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] shd_q, shd_d;
  logic             shd_vld_q, shd_vld_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;
  logic             run_q, run_d;
  logic             hi_q, hi_d;
  logic             hn_q, hn_d;
  logic             accept, legal, wrap;

  always_comb begin
    accept    = div.div_valid && rdy_q;
    legal     = div.div_in > WIDTH'(1);
    wrap      = (state_q != IDLE) && (cnt_q == div_q - 1'b1);
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    shd_d     = shd_q;
    shd_vld_d = shd_vld_q;
    err_d     = accept && !legal;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A load in IDLE goes straight to D so a simultaneous en starts on it
        if (shd_vld_q) begin
          div_d     = shd_q;
          shd_vld_d = 1'b0;
        end else if (accept && legal) begin
          div_d = div.div_in;
        end
        if (en) state_d = RUN;
      end
      default: begin
        if (wrap) begin
          cnt_d = '0;
          if (shd_vld_q) begin
            div_d     = shd_q;
            shd_vld_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (accept && legal) begin
          shd_d     = div.div_in;
          shd_vld_d = 1'b1;
        end
        if (state_q == RUN) begin
          if (!en) state_d = STOP;
        end else if (wrap) begin
          state_d = en ? RUN : IDLE;
        end
      end
    endcase
    run_d = (state_d != IDLE);
    // WIDTH+1-bit compare keeps D>>1 exact at the top of the range
    hi_d  = run_d && ({1'b0, cnt_d} < ({1'b0, div_d} >> 1));
    rdy_d = !shd_vld_d;
    hn_d  = hi_q && div_q[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DEF_D;
      shd_q     <= '0;
      shd_vld_q <= 1'b0;
      rdy_q     <= 1'b1;
      err_q     <= 1'b0;
      run_q     <= 1'b0;
      hi_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shd_q     <= shd_d;
      shd_vld_q <= shd_vld_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      run_q     <= run_d;
      hi_q      <= hi_d;
    end
  end

  // Trails the posedge flop by half a cycle; only odd D lets it through
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) hn_q <= 1'b0;
    else          hn_q <= hn_d;
  end

`ifdef CLKDIV_TICK_EN
  logic tick_q, tick_d;

  always_comb begin
    tick_d = run_d && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_q <= 1'b0;
    else          tick_q <= tick_d;
  end

  assign tick = tick_q;
`endif

  assign clk_out       = hi_q | hn_q;
  assign running       = run_q;
  assign div.div_ready = rdy_q;
  assign div.div_err   = err_q;

endmodule

// File: tb/tb_clock_divider_gen.sv
// Bench for clock_divider_gen: half-cycle waveform model checked on every clk
// edge, plus directed scenarios with literal period/high-time expectations.
module tb_clock_divider_gen;
  localparam int WIDTH = 8;
  localparam int DEF   = 4;

  logic clk = 1'b0, reset_n = 1'b0, en = 1'b0;
  logic clk_out, running;
`ifdef CLKDIV_TICK_EN
  logic tick;
  int   ticks;
`endif

  clock_divider_gen_if #(.WIDTH(WIDTH)) dif();

  clock_divider_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .div     (dif),
    .clk_out (clk_out),
    .running (running)
`ifdef CLKDIV_TICK_EN
    ,
    .tick    (tick)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a period of D clocks is 2D half-cycles, the first D of them high.
  int m_on = 0, m_stop = 0, m_pos = 0, m_d = DEF, m_sh = 0, m_shv = 0;
  int m_rdy = 1, m_err = 0, m_acc, m_legal, m_was_on;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_on = 0; m_stop = 0; m_pos = 0; m_d = DEF; m_shv = 0; m_rdy = 1; m_err = 0;
    end else begin
      m_acc    = int'(dif.div_valid) & m_rdy;
      m_legal  = (int'(dif.div_in) >= 2) ? 1 : 0;
      m_was_on = m_on;
      if (!m_was_on) begin
        if (m_shv != 0) begin m_d = m_sh; m_shv = 0; end
        else if (m_acc != 0 && m_legal != 0) m_d = int'(dif.div_in);
        if (en) begin m_on = 1; m_stop = 0; m_pos = 0; end
      end else begin
        if (m_pos == m_d - 1) begin
          if (m_shv != 0) begin m_d = m_sh; m_shv = 0; end
          m_pos = 0;
          if (m_stop != 0) begin
            if (en) m_stop = 0; else m_on = 0;
          end else if (!en) m_stop = 1;
        end else begin
          m_pos++;
          if (m_stop == 0 && !en) m_stop = 1;
        end
        if (m_acc != 0 && m_legal != 0) begin m_sh = int'(dif.div_in); m_shv = 1; end
      end
      m_rdy = (m_shv != 0) ? 0 : 1;
      m_err = (m_acc != 0 && m_legal == 0) ? 1 : 0;
    end
  end

  always @(clk) begin
    #2;
    chk("clk_out", clk_out, (m_on != 0 && (2 * m_pos + (clk ? 0 : 1)) < m_d) ? 1 : 0);
    chk("running", running, m_on);
    chk("div_ready", dif.div_ready, m_rdy);
    chk("div_err", dif.div_err, m_err);
`ifdef CLKDIV_TICK_EN
    chk("tick", tick, (m_on != 0 && m_pos == 0) ? 1 : 0);
`endif
  end

  time rises[$], falls[$], t0, tp;
  always @(posedge clk_out) rises.push_back($time);
  always @(negedge clk_out) falls.push_back($time);

  function automatic time qat(input time q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 0;
  endfunction

  function automatic time first_after(input time q[$], input time t);
    foreach (q[i]) if (q[i] > t) return q[i];
    return 0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic load(input int d);
    dif.div_in    = WIDTH'(d);
    dif.div_valid = 1'b1;
    cyc(1);
    dif.div_valid = 1'b0;
  endtask

  initial begin
    dif.div_in = '0; dif.div_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_running", running, 0);
    chk("rst_ready", dif.div_ready, 1);
    chk("rst_err", dif.div_err, 0);
    chk("rst_model_d", m_d, 4);
    cyc(1);

    // D=4 start: first rise on the first RUN posedge
    rises.delete(); falls.delete(); t0 = $time; en = 1'b1;
    cyc(13);
    chk("first_rise", qat(rises, 0) - t0, 7);
    chk("period4", qat(rises, 1) - qat(rises, 0), 40);
    chk("high4", first_after(falls, qat(rises, 0)) - qat(rises, 0), 20);
    chk("run_hi", running, 1);

    // D=5 loaded mid-period: current period still 4
    tp = qat(rises, rises.size() - 1);
    rises.delete(); falls.delete();
    load(5);
    chk("ready_low", dif.div_ready, 0);
    cyc(19);
    chk("wrap_at4", qat(rises, 0) - tp, 40);
    chk("period5", qat(rises, 1) - qat(rises, 0), 50);
    chk("high5", first_after(falls, qat(rises, 0)) - qat(rises, 0), 25);
    chk("ready_back", dif.div_ready, 1);

    // illegal divisors
    load(1);
    chk("err1", dif.div_err, 1);
    chk("err1_ready", dif.div_ready, 1);
    cyc(1);
    chk("err1_clr", dif.div_err, 0);
    load(0);
    chk("err0", dif.div_err, 1);
    cyc(1);
    chk("err0_clr", dif.div_err, 0);
    rises.delete();
    cyc(12);
    chk("period_kept", qat(rises, 1) - qat(rises, 0), 50);

    // D=6, en dropped at cnt=1
    load(6);
    cyc(14);
    for (int i = 0; i < 20 && m_pos != 1; i++) cyc(1);
    chk("sync1", m_pos, 1);
    chk("model_d6", m_d, 6);
    tp = qat(rises, rises.size() - 1);
    rises.delete(); falls.delete();
    en = 1'b0;
    cyc(12);
    chk("stop_no_rise", rises.size(), 0);
    chk("stop_high6", first_after(falls, tp) - tp, 30);
    chk("idle_clk", clk_out, 0);
    chk("idle_running", running, 0);

    // D=255 loaded together with en, then reset mid-high
    rises.delete(); falls.delete(); t0 = $time;
    dif.div_in = WIDTH'(255); dif.div_valid = 1'b1; en = 1'b1;
    cyc(1);
    dif.div_valid = 1'b0;
    chk("model_d255", m_d, 255);
    chk("first_rise255", qat(rises, 0) - t0, 7);
    cyc(60);
    chk("high255", clk_out, 1);
    chk("no_fall255", falls.size(), 0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_clk", clk_out, 0);
    chk("rst_mid_run", running, 0);
    en = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    // default divisor after reset; load arriving on the wrap edge
    rises.delete(); en = 1'b1;
    cyc(13);
    chk("period_def", qat(rises, 1) - qat(rises, 0), 40);
    for (int i = 0; i < 20 && m_pos != 3; i++) cyc(1);
    chk("sync3", m_pos, 3);
    rises.delete(); falls.delete();
    load(3);
    cyc(14);
    chk("wrap_load_keep4", qat(rises, 1) - qat(rises, 0), 40);
    chk("period3", qat(rises, 2) - qat(rises, 1), 30);
    chk("high3", first_after(falls, qat(rises, 1)) - qat(rises, 1), 15);

`ifdef CLKDIV_TICK_EN
    ticks = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      if (tick) begin
        ticks++;
        chk("tick_on_rise", qat(rises, rises.size() - 1), $time - 3);
      end
    end
    chk("tick_count", ticks, 3);
`endif

    // smallest legal divisor
    load(2);
    cyc(12);
    chk("period2", qat(rises, rises.size() - 1) - qat(rises, rises.size() - 2), 20);
    chk("high2", first_after(falls, qat(rises, rises.size() - 2)) - qat(rises, rises.size() - 2), 10);

    en = 1'b0;
    cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
